// File: rtl/apb_pkg.sv
// Shared types and widths for the APB master controller.
//   apb_state_e : 2-bit controller state
//   APB_ADDR_W  : APB address width
//   APB_DATA_W  : APB data width
//   ERR_CNT_W   : width of the saturating error counter
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int ERR_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait timer for the APB master.
// Down-counter loaded with TIMEOUT_CYCLES-1 while clear is high; every
// enabled cycle decrements it, and the enabled cycle that finds it at zero
// is the TIMEOUT_CYCLES-th waited cycle, which raises expired.
//   pclk    : clock
//   preset  : synchronous active-high reset (counter to 0)
//   clear   : reload the counter (held while not in ACCESS)
//   enable  : count this cycle (ACCESS with pready low)
//   expired : the current enabled cycle is the last one allowed
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LOAD_VAL = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = LOAD_VAL;
    end else if (enable && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && !clear && (cnt_q == 8'd0);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master controller: turns a valid/ready command into one APB transfer
// (SETUP then ACCESS) and returns the result on a valid/ready response port.
// Optional ACCESS timeout when APB_MASTER_TIMEOUT_EN is defined; otherwise
// ACCESS waits for pready indefinitely.
//
// Ports:
//   pclk, preset                   : clock, synchronous active-high reset
//   cmd_valid/cmd_ready            : command handshake
//   cmd_write, cmd_addr, cmd_wdata : command contents
//   rsp_valid/rsp_ready            : response handshake
//   rsp_rdata, rsp_slverr          : read data (0 for writes), error flag
//   err_count                      : saturating count of error responses
//   psel, penable, pwrite          : APB control
//   paddr, pwdata                  : APB address / write data
//   prdata, pready, pslverr        : APB slave response
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// SETUP  | psel=1 penable=0, one cycle
// ACCESS | psel=1 penable=1, waiting for pready (or timeout)
// RESP   | rsp_valid=1, waiting for rsp_ready
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [APB_ADDR_W-1:0] cmd_addr,
  input  logic [APB_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic [APB_DATA_W-1:0] pwdata,
  input  logic [APB_DATA_W-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("apb_master_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  apb_state_e            state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  pwrite_q, pwrite_d;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  logic wait_clear;
  logic wait_en;

  assign wait_clear = (state_q != ACCESS);
  assign wait_en    = (state_q == ACCESS) && !pready;

  apb_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .pclk    (pclk),
    .preset  (preset),
    .clear   (wait_clear),
    .enable  (wait_en),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      IDLE: begin
        // cmd_ready_q is low in the first cycle out of reset, so no accept there
        if (cmd_valid && cmd_ready_q) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_rdata_d  = pwrite_q ? '0 : prdata;
          rsp_slverr_d = pslverr;
          if (pslverr) begin
            err_cnt_d = sat_inc(err_cnt_q);
          end
          state_d = RESP;
        end else if (timeout_hit) begin
          rsp_rdata_d  = '0;
          rsp_slverr_d = 1'b1;
          err_cnt_d    = sat_inc(err_cnt_q);
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign psel       = (state_q == SETUP) || (state_q == ACCESS);
  assign penable    = (state_q == ACCESS);
  assign rsp_valid  = (state_q == RESP);
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl. Inputs are driven and outputs checked
// 1 time unit after each rising edge. With APB_MASTER_TIMEOUT_EN defined the
// DUT is built with TIMEOUT_CYCLES=4 and the abort path is exercised.
module tb_apb_master_ctrl;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 16;
`endif

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic [7:0]  err_count;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  apb_master_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .pclk       (pclk),
    .preset     (preset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .err_count  (err_count),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Full transfer with pready high from the start; expects minimum latency.
  task automatic do_xfer(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] slv_rdata,
                         input logic slverr, input logic [31:0] exp_rdata,
                         input logic [7:0] exp_err);
    chk({tag, ".idle_ready"}, cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    pready = 1; prdata = slv_rdata; pslverr = slverr;
    tick();                                  // T+1: SETUP, pready ignored
    cmd_valid = 0;
    chk({tag, ".setup_psel"},    psel, 1);
    chk({tag, ".setup_penable"}, penable, 0);
    chk({tag, ".setup_ready"},   cmd_ready, 0);
    chk({tag, ".paddr"},  paddr, addr);
    chk({tag, ".pwdata"}, pwdata, wdata);
    chk({tag, ".pwrite"}, pwrite, wr);
    tick();                                  // T+2: ACCESS
    chk({tag, ".acc_psel"},    psel, 1);
    chk({tag, ".acc_penable"}, penable, 1);
    chk({tag, ".acc_rsp_valid"}, rsp_valid, 0);
    tick();                                  // T+3: RESP
    pready = 0;
    chk({tag, ".rsp_valid"},  rsp_valid, 1);
    chk({tag, ".rsp_psel"},   psel, 0);
    chk({tag, ".rsp_penable"}, penable, 0);
    chk({tag, ".rsp_rdata"},  rsp_rdata, exp_rdata);
    chk({tag, ".rsp_slverr"}, rsp_slverr, slverr);
    chk({tag, ".err_count"},  err_count, exp_err);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk({tag, ".done_valid"}, rsp_valid, 0);
    chk({tag, ".done_ready"}, cmd_ready, 1);
  endtask

  task automatic quiet_err_xfer();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h40; cmd_wdata = 0;
    pready = 1; pslverr = 1; prdata = 0;
    tick(); cmd_valid = 0;
    tick();
    tick(); pready = 0; pslverr = 0; rsp_ready = 1;
    tick(); rsp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0; prdata = 0; pready = 0; pslverr = 0;
    tick(); tick();
    chk("rst.psel", psel, 0);
    chk("rst.penable", penable, 0);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.cmd_ready", cmd_ready, 0);
    chk("rst.err_count", err_count, 0);
    chk("rst.paddr", paddr, 0);
    preset = 0;
    tick();
    chk("rst.ready_after", cmd_ready, 1);

    do_xfer("wr5", 1, 32'd5, 32'hDEADBEEF, 32'h1111_2222, 0, 32'h0, 8'd0);
    do_xfer("rd5", 0, 32'd5, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 8'd0);
    do_xfer("rd40", 0, 32'd40, 32'h0, 32'h5555_AAAA, 1, 32'h5555_AAAA, 8'd1);

    // Wait states on the slave side and back-pressure on the response side.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h100; cmd_wdata = 32'h12345678;
    pready = 0; prdata = 32'hA5A5_5A5A; pslverr = 0;
    tick(); cmd_valid = 0;
    chk("ws.setup_psel", psel, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ws.acc_penable", penable, 1);
      chk("ws.acc_paddr", paddr, 32'h100);
      chk("ws.acc_pwdata", pwdata, 32'h12345678);
      chk("ws.acc_cmd_ready", cmd_ready, 0);
      chk("ws.acc_rsp_valid", rsp_valid, 0);
    end
    pready = 1;
    tick();
    pready = 0; prdata = 32'h0BAD_0BAD; pslverr = 1;
    for (int i = 0; i < 4; i++) begin
      chk("bp.rsp_valid", rsp_valid, 1);
      chk("bp.rsp_rdata", rsp_rdata, 32'hA5A5_5A5A);
      chk("bp.rsp_slverr", rsp_slverr, 0);
      chk("bp.cmd_ready", cmd_ready, 0);
      chk("bp.psel", psel, 0);
      tick();
    end
    chk("bp.still_valid", rsp_valid, 1);
    rsp_ready = 1; pslverr = 0;
    tick(); rsp_ready = 0;
    chk("bp.done_valid", rsp_valid, 0);
    chk("bp.done_ready", cmd_ready, 1);
    chk("bp.err_count", err_count, 1);

    // Slave never answers.
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h44; cmd_wdata = 0;
    pready = 0;
    tick(); cmd_valid = 0;
    tick();
    chk("to.access", penable, 1);
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to.still_access", penable, 1);
    end
    tick();
    chk("to.rsp_valid", rsp_valid, 1);
    chk("to.psel", psel, 0);
    chk("to.penable", penable, 0);
    chk("to.rsp_slverr", rsp_slverr, 1);
    chk("to.rsp_rdata", rsp_rdata, 0);
    chk("to.err_count", err_count, 2);
    rsp_ready = 1;
    tick(); rsp_ready = 0;
    chk("to.done_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h48; cmd_wdata = 32'h77;
    tick(); cmd_valid = 0;
    tick(); tick();
    chk("mid.access", penable, 1);
`else
    for (int i = 0; i < 100; i++) tick();
    chk("nto.psel", psel, 1);
    chk("nto.penable", penable, 1);
    chk("nto.rsp_valid", rsp_valid, 0);
`endif

    // Reset in the middle of ACCESS abandons the transfer.
    preset = 1;
    tick();
    chk("mid.psel", psel, 0);
    chk("mid.penable", penable, 0);
    chk("mid.rsp_valid", rsp_valid, 0);
    chk("mid.err_count", err_count, 0);
    chk("mid.cmd_ready", cmd_ready, 0);
    preset = 0;
    pready = 1;
    tick();
    chk("mid.ready_after", cmd_ready, 1);
    chk("mid.no_rsp", rsp_valid, 0);
    tick();
    chk("mid.no_rsp2", rsp_valid, 0);
    chk("mid.idle_psel", psel, 0);
    pready = 0;

    // Saturation of the error counter.
    for (int i = 0; i < 255; i++) quiet_err_xfer();
    chk("sat.at_255", err_count, 255);
    quiet_err_xfer();
    chk("sat.hold_255", err_count, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
